fifo_burst_drain: RTL and testbench

- Downstream consumer of the 128x64 single-clock FIFO.
- Drains 64-bit words from the FIFO read port and emits them as framed bursts (sop/eop/len) on a valid/ready stream toward the DMA/host-write stage.
- A full burst is issued when BURST_LEN words are available; a partial burst is flushed on an idle timeout or on an explicit flush request.
- A small internal skid buffer absorbs FIFO read latency, so back-pressure never drops or duplicates a word.

---
 rtl/fifo_burst_drain.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fifo_burst_drain.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
// Drains a single-clock FIFO into framed bursts (sop/eop/len) on a valid/ready stream.
// Full bursts of BURST_LEN words; partial bursts on idle timeout or flush request.
module fifo_burst_drain #(
   parameter int BURST_LEN  = 16,
   parameter int TIMEOUT    = 256,
   parameter int RD_LAT     = 1,
   parameter int SKID_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] fifo_q,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_usedw,
   output logic        fifo_rdreq,
   input  logic        flush,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop,
   output logic [6:0]  out_len,
   output logic [31:0] burst_cnt,
   output logic [15:0] partial_cnt,
   output logic        busy
);

   localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int CW = $clog2(SKID_DEPTH + 1) + 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [6:0]    BURST_LEN_L = 7'(BURST_LEN);
   localparam logic [7:0]    BURST_LEN_U = 8'(BURST_LEN);
   localparam logic [TW-1:0] TIMEOUT_V   = TW'(TIMEOUT);
   localparam logic          TIMEOUT_EN  = (TIMEOUT != 0);
   localparam logic [CW-1:0] DEPTH_V     = CW'(SKID_DEPTH);
   localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [PW-1:0] PTR_LAST    = PW'(SKID_DEPTH - 1);
   localparam logic [PW-1:0] PTR_ZERO    = PW'(0);
   localparam logic [PW-1:0] PTR_ONE     = PW'(1);
   localparam logic [TW-1:0] TMR_ZERO    = TW'(0);
   localparam logic [TW-1:0] TMR_ONE     = TW'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;

   logic [6:0]      len_r;
   logic [6:0]      rem_r;
   logic [TW-1:0]   timer_r;
   logic [31:0]     burst_cnt_r;
   logic [15:0]     partial_cnt_r;

   logic [RD_LAT-1:0] tag_vld_r;
   logic [RD_LAT-1:0] tag_sop_r;
   logic [RD_LAT-1:0] tag_eop_r;
   logic [6:0]        tag_len_r [RD_LAT];
   logic [CW-1:0]     inflight_r;

   logic [63:0]           skid_data_r [SKID_DEPTH];
   logic [SKID_DEPTH-1:0] skid_sop_r;
   logic [SKID_DEPTH-1:0] skid_eop_r;
   logic [6:0]            skid_len_r [SKID_DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         occ_r;

   logic trig_full_s;
   logic trig_part_s;
   logic timeout_hit_s;
   logic credit_ok_s;
   logic rd_en_s;
   logic tag_sop_s;
   logic tag_eop_s;
   logic start_full_s;
   logic start_part_s;
   logic push_s;
   logic pop_s;
   logic out_valid_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PTR_LAST) begin
         return PTR_ZERO;
      end else begin
         return p + PTR_ONE;
      end
   endfunction

   assign timeout_hit_s = TIMEOUT_EN && (timer_r == TIMEOUT_V);
   assign trig_full_s   = (fifo_usedw >= BURST_LEN_U);
   assign trig_part_s   = (fifo_usedw != 8'd0) && (flush || timeout_hit_s);
   // Reserve a skid slot for every read still travelling through the FIFO pipe.
   assign credit_ok_s   = ((occ_r + inflight_r + CNT_ONE) <= DEPTH_V);
   assign push_s        = tag_vld_r[RD_LAT-1];
   assign out_valid_s   = (occ_r != CNT_ZERO);
   assign pop_s         = out_valid_s && out_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_full_s || start_part_s) begin
               state_nxt_s = ST_BURST;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (rd_en_s && tag_eop_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BURST;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode: burst start strobes, read issue and read tags
   always_comb begin
      rd_en_s      = 1'b0;
      start_full_s = 1'b0;
      start_part_s = 1'b0;
      tag_sop_s    = 1'b0;
      tag_eop_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (trig_full_s) begin
               start_full_s = 1'b1;
            end else if (trig_part_s) begin
               start_part_s = 1'b1;
            end else begin
               start_full_s = 1'b0;
               start_part_s = 1'b0;
            end
         end
         ST_BURST: begin
            // fifo_empty gating keeps the FIFO underflow flag at zero.
            if (!rst && (rem_r != 7'd0) && credit_ok_s && !fifo_empty) begin
               rd_en_s = 1'b1;
            end else begin
               rd_en_s = 1'b0;
            end
            tag_sop_s = (rem_r == len_r);
            tag_eop_s = (rem_r == 7'd1);
         end
         default: begin
            rd_en_s = 1'b0;
         end
      endcase
   end

   // Burst length/remaining counters, idle timer and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         len_r         <= 7'd0;
         rem_r         <= 7'd0;
         timer_r       <= TMR_ZERO;
         burst_cnt_r   <= 32'd0;
         partial_cnt_r <= 16'd0;
      end else begin
         if (start_full_s) begin
            len_r <= BURST_LEN_L;
            rem_r <= BURST_LEN_L;
         end else if (start_part_s) begin
            len_r <= fifo_usedw[6:0];
            rem_r <= fifo_usedw[6:0];
         end else if (rd_en_s) begin
            rem_r <= rem_r - 7'd1;
         end else begin
            rem_r <= rem_r;
         end

         if ((state_r != ST_IDLE) || start_full_s || start_part_s || (fifo_usedw == 8'd0)) begin
            timer_r <= TMR_ZERO;
         end else if (timer_r != TIMEOUT_V) begin
            timer_r <= timer_r + TMR_ONE;
         end else begin
            timer_r <= timer_r;
         end

         if (start_part_s && (partial_cnt_r != 16'hFFFF)) begin
            partial_cnt_r <= partial_cnt_r + 16'd1;
         end else begin
            partial_cnt_r <= partial_cnt_r;
         end

         if (pop_s && out_eop) begin
            burst_cnt_r <= burst_cnt_r + 32'd1;
         end else begin
            burst_cnt_r <= burst_cnt_r;
         end
      end
   end

   // Tag pipe matching the FIFO read latency, plus in-flight read count
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_r  <= '0;
         tag_sop_r  <= '0;
         tag_eop_r  <= '0;
         inflight_r <= CNT_ZERO;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_len_r[i] <= 7'd0;
         end
      end else begin
         tag_vld_r[0] <= rd_en_s;
         tag_sop_r[0] <= rd_en_s && tag_sop_s;
         tag_eop_r[0] <= rd_en_s && tag_eop_s;
         tag_len_r[0] <= len_r;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_r[i] <= tag_vld_r[i-1];
            tag_sop_r[i] <= tag_sop_r[i-1];
            tag_eop_r[i] <= tag_eop_r[i-1];
            tag_len_r[i] <= tag_len_r[i-1];
         end
         case ({rd_en_s, push_s})
            2'b10:   inflight_r <= inflight_r + CNT_ONE;
            2'b01:   inflight_r <= inflight_r - CNT_ONE;
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Skid buffer: captures fifo_q as its tag exits the pipe, head drives the stream
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         occ_r      <= CNT_ZERO;
         skid_sop_r <= '0;
         skid_eop_r <= '0;
      end else begin
         if (push_s) begin
            skid_data_r[wr_ptr_r] <= fifo_q;
            skid_sop_r[wr_ptr_r]  <= tag_sop_r[RD_LAT-1];
            skid_eop_r[wr_ptr_r]  <= tag_eop_r[RD_LAT-1];
            skid_len_r[wr_ptr_r]  <= tag_len_r[RD_LAT-1];
            wr_ptr_r              <= ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + CNT_ONE;
            2'b01:   occ_r <= occ_r - CNT_ONE;
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign fifo_rdreq  = rd_en_s;
   assign out_valid   = out_valid_s;
   assign out_data    = out_valid_s ? skid_data_r[rd_ptr_r] : 64'd0;
   assign out_sop     = out_valid_s && skid_sop_r[rd_ptr_r];
   assign out_eop     = out_valid_s && skid_eop_r[rd_ptr_r];
   assign out_len     = out_valid_s ? skid_len_r[rd_ptr_r] : 7'd0;
   assign burst_cnt   = burst_cnt_r;
   assign partial_cnt = partial_cnt_r;
   assign busy        = (state_r != ST_IDLE) || (occ_r != CNT_ZERO) || (inflight_r != CNT_ZERO);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: behavioural FIFO in front, scoreboard of expected beats behind.
module tb_fifo_burst_drain;

   localparam int BL  = 16;
   localparam int TO  = 256;
   localparam int RDL = 1;
   localparam int SD  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] fifo_q;
   logic        fifo_empty;
   logic [7:0]  fifo_usedw;
   logic        fifo_rdreq;
   logic        flush = 1'b0;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sop;
   logic        out_eop;
   logic [6:0]  out_len;
   logic [31:0] burst_cnt;
   logic [15:0] partial_cnt;
   logic        busy;

   logic        wr_en = 1'b0;
   logic [63:0] wr_data = 64'd0;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [6:0]  len;
   } beat_t;

   beat_t sb[$];
   beat_t mon_e;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int wr_idx = 0;
   int exp_idx = 0;
   int exp_bursts = 0;
   int exp_partials = 0;
   int first_wr_cyc = 0;
   int acc_cnt = 0;
   int sop_cyc = 0;
   int span = 0;
   int ready_mode = 0;
   logic        hold_pending = 1'b0;
   logic [63:0] held_data = 64'd0;

   fifo_burst_drain #(
      .BURST_LEN (BL),
      .TIMEOUT   (TO),
      .RD_LAT    (RDL),
      .SKID_DEPTH(SD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_usedw (fifo_usedw),
      .fifo_rdreq (fifo_rdreq),
      .flush      (flush),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_len    (out_len),
      .burst_cnt  (burst_cnt),
      .partial_cnt(partial_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 128-deep FIFO with one cycle of read latency
   logic [63:0] fmem [128];
   logic [6:0]  frd = 7'd0;
   logic [6:0]  fwr = 7'd0;
   logic [7:0]  fcnt = 8'd0;
   logic [63:0] fq = 64'd0;
   logic        fpop;

   assign fpop       = fifo_rdreq && (fcnt != 8'd0);
   assign fifo_q     = fq;
   assign fifo_empty = (fcnt == 8'd0);
   assign fifo_usedw = fcnt;

   always @(posedge clk) begin
      if (rst) begin
         frd  <= 7'd0;
         fwr  <= 7'd0;
         fcnt <= 8'd0;
         fq   <= 64'd0;
      end else begin
         if (fpop) begin
            fq  <= fmem[frd];
            frd <= frd + 7'd1;
         end
         if (wr_en) begin
            fmem[fwr] <= wr_data;
            fwr       <= fwr + 7'd1;
         end
         fcnt <= fcnt + (wr_en ? 8'd1 : 8'd0) - (fpop ? 8'd1 : 8'd0);
      end
   end

   // Downstream ready: always on, or alternating with random extra stalls
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) begin
         out_ready = (cyc % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      end else begin
         out_ready = 1'b1;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] wdata(input int idx);
      return {32'(idx) ^ 32'hC0DE_0000, 32'(idx)};
   endfunction

   // Output monitor: scoreboard compare, stall stability, read credit rule
   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_data", out_data, held_data);
         end
         if (fifo_rdreq) begin
            check_val("rdreq_while_empty", 64'(fifo_empty), 64'd0);
            check_val("skid_credit", 64'((64'(dut.occ_r) + 64'(dut.inflight_r) + 64'd1) <= 64'(SD)), 64'd1);
         end
         if (out_valid && out_ready) begin
            acc_cnt++;
            if (sb.size() == 0) begin
               check_val("unexpected_beat", 64'(sb.size()), 64'd1);
            end else begin
               mon_e = sb.pop_front();
               check_val("data", out_data, mon_e.d);
               check_val("sop", 64'(out_sop), 64'(mon_e.sop));
               check_val("eop", 64'(out_eop), 64'(mon_e.eop));
               if (mon_e.sop) check_val("len", 64'(out_len), 64'(mon_e.len));
               if (out_sop) sop_cyc = cyc;
               if (out_eop) span = cyc - sop_cyc;
            end
         end
         hold_pending = out_valid && !out_ready;
         held_data    = out_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preload(input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = wdata(wr_idx);
         wr_idx++;
         tick(1);
         if (i == 0) first_wr_cyc = cyc;
      end
      wr_en = 1'b0;
   endtask

   task automatic plan(input int n, input bit partial);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d   = wdata(exp_idx);
         b.sop = (i == 0);
         b.eop = (i == n - 1);
         b.len = 7'(n);
         sb.push_back(b);
         exp_idx++;
      end
      exp_bursts++;
      if (partial) exp_partials++;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      bit done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (sb.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
         tick(1);
      end
      check_val(tag, 64'(done), 64'd1);
      check_val({tag, "_burst_cnt"}, 64'(burst_cnt), 64'(exp_bursts));
      check_val({tag, "_partial_cnt"}, 64'(partial_cnt), 64'(exp_partials));
   endtask

   initial begin
      int lat;
      int nv;
      int base;

      // reset state
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_rdreq", 64'(fifo_rdreq), 64'd0);
      check_val("rst_sop_eop_len", {55'd0, out_sop, out_eop, out_len}, 64'd0);
      check_val("rst_burst_cnt", 64'(burst_cnt), 64'd0);
      check_val("rst_partial_cnt", 64'(partial_cnt), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);

      // one full burst of 16, no bubbles
      plan(16, 1'b0);
      preload(16);
      wait_drain("full16", 200);
      check_val("full16_span", 64'(span), 64'd15);

      // 5 words left alone until the idle timeout fires
      plan(5, 1'b1);
      preload(5);
      wait_drain("timeout5", 600);
      check_val("timeout5_latency", 64'(sop_cyc - first_wr_cyc), 64'(TO + 2 + RDL));

      // 3 words forced out by flush
      plan(3, 1'b1);
      preload(3);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         if (out_valid) begin
            lat = k;
            break;
         end
         tick(1);
      end
      check_val("flush3_latency", 64'(lat), 64'(2 + RDL));
      wait_drain("flush3", 100);

      // flush against an empty FIFO is ignored
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      nv = 0;
      for (int k = 0; k < 20; k++) begin
         nv += int'(out_valid);
         tick(1);
      end
      check_val("flush_empty_quiet", 64'(nv), 64'd0);
      check_val("flush_empty_partial", 64'(partial_cnt), 64'(exp_partials));

      // 40 words with stalls: 16 + 16 + 8-word timeout partial
      plan(16, 1'b0);
      plan(16, 1'b0);
      plan(8, 1'b1);
      ready_mode = 1;
      preload(40);
      wait_drain("stall40", 2000);
      ready_mode = 0;
      tick(2);

      // reset in the middle of a burst, then a clean burst
      base = acc_cnt;
      plan(16, 1'b0);
      preload(16);
      for (int k = 0; k < 200; k++) begin
         if (acc_cnt >= base + 8) break;
         tick(1);
      end
      check_val("midrst_point", 64'(acc_cnt >= base + 8), 64'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      sb.delete();
      exp_idx = wr_idx;
      exp_bursts = 0;
      exp_partials = 0;
      check_val("midrst_out_valid", 64'(out_valid), 64'd0);
      check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_burst_cnt", 64'(burst_cnt), 64'd0);
      check_val("midrst_partial_cnt", 64'(partial_cnt), 64'd0);
      plan(16, 1'b0);
      preload(16);
      wait_drain("post_rst16", 200);
      check_val("post_rst16_span", 64'(span), 64'd15);

      // single-word burst via flush
      plan(1, 1'b1);
      preload(1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      wait_drain("single1", 100);
      check_val("single1_span", 64'(span), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
